// File: rtl/vt_pkg.sv
// Shared constants, state encoding and row-address helper for the
// Apple 1 video terminal write path.
package vt_pkg;

    localparam int COLS         = 40;
    localparam int ROWS         = 24;
    localparam int SCREEN_CELLS = COLS * ROWS;

    localparam logic [6:0] CHAR_CR    = 7'h0D;
    localparam logic [5:0] CHAR_SPACE = 6'h20;
    localparam logic [6:0] PRINT_LO   = 7'h20;
    localparam logic [6:0] PRINT_HI   = 7'h5F;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        NEWLINE,
        CLEAR_LINE,
        CLEAR_SCREEN,
        WAIT_DA_LOW
    } state_t;

    // r*40 built from two shifts so no multiplier is inferred
    function automatic logic [9:0] row_base(input logic [4:0] r);
        return ({5'd0, r} << 5) + ({5'd0, r} << 3);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a registered
// rising-edge pulse aligned to the first cycle the synchronised level is high.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta;

    // metastability stage, stable level, and edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= async_in;
            level <= meta;
            rise  <= meta & ~level;
        end
    end

endmodule

// File: rtl/terminal_write_ctrl.sv
// Write-side controller for the video terminal: takes characters over the
// DA/RDA handshake, handles CR, wrap, scroll and clear-screen, and issues
// screen RAM writes only in cycles granted by wr_slot.
module terminal_write_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:1] rd,
    input  logic       da,
    output logic       rda_n,
    input  logic       clr_btn,
    input  logic       wr_slot,
    output logic       ram_we,
    output logic [9:0] ram_addr,
    output logic [5:0] ram_wdata,
    output logic [4:0] top_row,
    output logic [9:0] cur_addr,
    output logic       busy
);
    import vt_pkg::*;

    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [9:0] LAST_CELL = 10'(COLS * ROWS - 1);
    localparam logic [5:0] ROWS6     = 6'(ROWS);

    state_t     state, next_state;
    logic       da_sync, da_rise_unused;
    logic       clr_sync_unused, clr_rise;
    logic [6:0] char_q;
    logic [4:0] row;
    logic [5:0] col;
    logic [9:0] fill_cnt;
    logic       fill_last;
    logic       printable;
    logic [5:0] phys_sum;
    logic [4:0] phys_row;

    sync_edge u_da_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (da),
        .level    (da_sync),
        .rise     (da_rise_unused)
    );

    sync_edge u_clr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (clr_btn),
        .level    (clr_sync_unused),
        .rise     (clr_rise)
    );

    // the row index into the circular screen buffer, plus fill-end detect
    always_comb begin
        phys_sum  = {1'b0, top_row} + {1'b0, row};
        phys_row  = (phys_sum >= ROWS6) ? 5'(phys_sum - ROWS6) : phys_sum[4:0];
        printable = (char_q >= PRINT_LO) && (char_q <= PRINT_HI);
        fill_last = (state == CLEAR_LINE) ? (fill_cnt == {4'd0, LAST_COL})
                                          : (fill_cnt == LAST_CELL);
    end

    // state register; reset lands in the screen fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR_SCREEN;
        else        state <= next_state;
    end

    // next-state and handshake / write-enable outputs
    always_comb begin
        next_state = state;
        rda_n      = (state != IDLE);
        busy       = (state != IDLE);
        ram_we     = wr_slot & ((state == WRITE) || (state == CLEAR_LINE) ||
                                (state == CLEAR_SCREEN));
        case (state)
            IDLE:         if (da_sync) next_state = DECODE;
            DECODE: begin
                if (char_q == CHAR_CR) next_state = NEWLINE;
                else if (printable)    next_state = WRITE;
                else                   next_state = WAIT_DA_LOW;
            end
            WRITE:        if (wr_slot) next_state = (col == LAST_COL) ? NEWLINE : WAIT_DA_LOW;
            NEWLINE:      next_state = (row == LAST_ROW) ? CLEAR_LINE : WAIT_DA_LOW;
            CLEAR_LINE,
            CLEAR_SCREEN: if (wr_slot && fill_last) next_state = WAIT_DA_LOW;
            WAIT_DA_LOW:  if (!da_sync) next_state = IDLE;
            default:      next_state = CLEAR_SCREEN;
        endcase
        // clear button wins over everything, including a restart mid-fill
        if (clr_rise) next_state = CLEAR_SCREEN;
    end

    // cursor, scroll origin, fill counter and registered RAM address/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            top_row   <= '0;
            fill_cnt  <= '0;
            char_q    <= '0;
            ram_addr  <= '0;
            ram_wdata <= CHAR_SPACE;
        end else if (clr_rise) begin
            row       <= '0;
            col       <= '0;
            top_row   <= '0;
            fill_cnt  <= '0;
            ram_addr  <= '0;
            ram_wdata <= CHAR_SPACE;
        end else begin
            case (state)
                IDLE: if (da_sync) char_q <= rd;
                DECODE: begin
                    ram_addr  <= cur_addr;
                    ram_wdata <= char_q[5:0];
                end
                WRITE: if (wr_slot && col != LAST_COL) col <= col + 6'd1;
                NEWLINE: begin
                    col <= '0;
                    if (row != LAST_ROW) begin
                        row <= row + 5'd1;
                    end else begin
                        // old top line becomes the new bottom line: blank it
                        top_row   <= (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
                        fill_cnt  <= '0;
                        ram_addr  <= row_base(top_row);
                        ram_wdata <= CHAR_SPACE;
                    end
                end
                CLEAR_LINE, CLEAR_SCREEN: begin
                    if (wr_slot && !fill_last) begin
                        fill_cnt <= fill_cnt + 10'd1;
                        ram_addr <= ram_addr + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // cursor cell address, one cycle behind the cursor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_addr <= '0;
        else        cur_addr <= row_base(phys_row) + {4'd0, col};
    end

endmodule

// File: doc/terminal_write_ctrl.md
# terminal_write_ctrl

Write-side controller for the Apple 1 video terminal. It accepts 7-bit characters from the PIA over the DA/RDA handshake and interprets carriage return, cursor advance, scroll and clear-screen. It sequences all writes into the shared 40×24 screen RAM, and only writes in cycles granted by the video timing generator's `wr_slot` strobe. It sits between the `rd`/`da`/`rda_n`/`clr_btn` pins and the screen RAM write port inside `video_terminal`.

## Interface
- `COLS`, 40, characters per row
- `ROWS`, 24, rows per screen
- `clk`  in  1  pixel-domain clock (PLL output gated by lock)
- `rst_n`  in  1  reset; asynchronous, active-low
- `rd`  in  7 (`[7:1]`)  character from PIA; `rd[1]` is the LSB
- `da`  in  1  data available, active-high, asynchronous to `clk`
- `rda_n`  out  1  ready-for-data, active-low; the top level inverts it onto the `rda` pin
- `clr_btn`  in  1  clear-screen button, asynchronous, active-high
- `wr_slot`  in  1  one-cycle grant: the screen RAM write port is free this cycle
- `ram_we`  out  1  screen RAM write enable
- `ram_addr`  out  10  physical cell address, `phys_row*40 + col`, range 0..959
- `ram_wdata`  out  6  character code, `rd[6:1]`; space is 6'h20
- `top_row`  out  5  physical row shown as the top display line, range 0..23
- `cur_addr`  out  10  physical address of the cursor cell, used for cursor blink
- `busy`  out  1  high in every state except IDLE

## Operation
- `da` and `clr_btn` each pass through a 2-flop synchroniser. `clr_btn` also gets rising-edge detection.
- Logical cursor is (`row` 0..23, `col` 0..39).
- `phys_row = (top_row + row) mod 24`, computed with a single conditional subtract of 24.
- `row*40` is built as `(row<<5)+(row<<3)`.

State machine and transitions:
- **IDLE**: `rda_n=0`. When synchronised `da` is 1: latch `rd`, set `rda_n=1`, go to DECODE.
- **DECODE**: one cycle.
  - Code 7'h0D (CR) → NEWLINE.
  - Codes 7'h20..7'h5F → WRITE.
  - All other codes → WAIT_DA_LOW, character discarded.
- **WRITE**: hold `ram_addr=cur_addr` and `ram_wdata=char[5:0]`. On the first `wr_slot`, the write occurs. Then:
  - if `col==39` → NEWLINE;
  - else `col++` → WAIT_DA_LOW.
- **NEWLINE**: `col=0`.
  - If `row<23`: `row++` → WAIT_DA_LOW.
  - If `row==23`: record the old `top_row` as the row to clear, set `top_row=(top_row+1) mod 24` (23 wraps to 0), → CLEAR_LINE.
- **CLEAR_LINE**: write 6'h20 to the 40 cells of the recorded physical row, one cell per `wr_slot`, columns 0..39. Then → WAIT_DA_LOW.
- **WAIT_DA_LOW**: `rda_n=1` until synchronised `da` is 0, then → IDLE.
- **CLEAR_SCREEN**:
  - On entry: `top_row=0`, `row=0`, `col=0`, fill counter=0.
  - Write 6'h20 to addresses 0..959 in order, one per `wr_slot`.
  - Then → WAIT_DA_LOW.

Clear-screen and reset rules:
- A `clr_btn` rising edge in any state forces CLEAR_SCREEN on the next cycle. The current character or line clear is abandoned; a write granted in the same cycle as the edge still completes.
- An edge during CLEAR_SCREEN restarts the fill at address 0.
- Reset enters CLEAR_SCREEN.

## Timing
- Reset values:
  - `rda_n=1`, `busy=1`, `ram_we=0`
  - `ram_addr=0`, `ram_wdata=6'h20`
  - `top_row=0`, `cur_addr=0`
  - state=CLEAR_SCREEN
- `ram_we = wr_slot & (state is WRITE/CLEAR_LINE/CLEAR_SCREEN)` is combinational, so the write lands in the granted cycle. `ram_addr` and `ram_wdata` are registered and stable before the grant.
- `da` rising at the pin → `rda_n` high within 3 `clk` cycles: 2 synchroniser cycles plus the IDLE capture.
- A character is never accepted while `rda_n` is high. `rda_n` returns low no earlier than 2 cycles after `da` falls at the pin.
- Printable character latency is DECODE plus the wait for the first `wr_slot` after entering WRITE.
- Scroll costs exactly 40 granted slots; clear-screen costs exactly 960.
- `cur_addr` updates in the cycle after `col`, `row` or `top_row` changes.
- `wr_slot` pulses while in IDLE, DECODE, NEWLINE or WAIT_DA_LOW are ignored.

## Structure
- Package `vt_pkg` holds:
  - `COLS`, `ROWS`, `SCREEN_CELLS=960`
  - `CHAR_CR=7'h0D`, `CHAR_SPACE=6'h20`
  - printable bounds 7'h20 and 7'h5F
  - the state enum: IDLE, DECODE, WRITE, NEWLINE, CLEAR_LINE, CLEAR_SCREEN, WAIT_DA_LOW
- Sub-module `sync_edge`: a 2-flop synchroniser with registered rising-edge output. It is instantiated twice, once for `da` and once for `clr_btn`.

## Test plan
- **Reset fill**: release `rst_n` with `wr_slot` every 4 cycles → exactly 960 writes of 6'h20 to addresses 0..959 in order, then `rda_n` goes low and `busy` goes low.
- **Printable handshake**: `rd=7'h41`, pulse `da` → `rda_n` high within 3 cycles; one write of 6'h01 to address 0; `cur_addr=1`; `rda_n` low only after `da` falls.
- **Line wrap and CR**: send 40 printable chars → col-39 write at address 39, then `cur_addr=40`. Then send 7'h0D from `col=5` on row 1 → `cur_addr=80`, no RAM write.
- **Scroll**: cursor on row 23, `top_row=0`, send CR → `top_row=1`; 40 writes of 6'h20 to addresses 0..39; `cur_addr=0`. After 24 scrolls `top_row` wraps to 0.
- **Ignored codes**: send 7'h07 and 7'h61 → no `ram_we`, cursor unchanged, handshake still completes.
- **Clear mid-scroll**: assert `clr_btn` after 10 CLEAR_LINE writes → fill restarts at address 0, `top_row=0`, 960 writes. Asserting `rst_n` low mid-fill → outputs return to reset values asynchronously.
